// File: rtl/usb_tx_buffer_if.sv
// rtl/usb_tx_buffer_if.sv - bus bundle between the command decoder, the TX buffer and the USB FIFO
//
// Purpose:
//    Groups the write/complete side (tx_*), the USB FIFO side (usb_*) and
//    the buffer status flags into one interface.
//
// Modports:
//    slave  - the buffer: takes tx_vd/tx_addr/tx_data/tx_eop/tx_baddr and
//             usb_full, drives usb_wr/usb_dout/usb_pktend/tx_busy/tx_ovf.
//    master - the surrounding logic: the mirror image of slave.
//
// Signals:
//    tx_vd      write strobe; tx_data is stored at tx_addr
//    tx_addr    {bank, word} write address
//    tx_data    write data
//    tx_eop     one-cycle pulse, bank tx_baddr is complete
//    tx_baddr   completed bank index, qualified by tx_eop
//    usb_full   USB FIFO full
//    usb_wr     USB FIFO write, one word per cycle while high
//    usb_dout   USB FIFO data, valid while usb_wr is high
//    usb_pktend packet-end pulse
//    tx_busy    a bank is pending or being sent
//    tx_ovf     sticky overflow flag

interface usb_tx_buffer_if #(
   parameter int USB_DATA_NBIT     = 16,
   parameter int USB_ADDR_NBIT     = 8,
   parameter int BUFFER_BADDR_NBIT = 2
);
   localparam int BUFFER_ADDR_NBIT = BUFFER_BADDR_NBIT + USB_ADDR_NBIT;

   logic                          tx_vd;
   logic [BUFFER_ADDR_NBIT-1:0]   tx_addr;
   logic [USB_DATA_NBIT-1:0]      tx_data;
   logic                          tx_eop;
   logic [BUFFER_BADDR_NBIT-1:0]  tx_baddr;
   logic                          usb_full;
   logic                          usb_wr;
   logic [USB_DATA_NBIT-1:0]      usb_dout;
   logic                          usb_pktend;
   logic                          tx_busy;
   logic                          tx_ovf;

   modport master (
      output tx_vd, tx_addr, tx_data, tx_eop, tx_baddr, usb_full,
      input  usb_wr, usb_dout, usb_pktend, tx_busy, tx_ovf
   );

   modport slave (
      input  tx_vd, tx_addr, tx_data, tx_eop, tx_baddr, usb_full,
      output usb_wr, usb_dout, usb_pktend, tx_busy, tx_ovf
   );
endinterface

// File: rtl/usb_tx_buffer.sv
// rtl/usb_tx_buffer.sv - banked packet buffer draining completed banks into a USB FIFO
//
// Purpose:
//    2^BUFFER_BADDR_NBIT banks of 2^USB_ADDR_NBIT words are filled through
//    the write port. A tx_eop marks a bank ready; ready banks are streamed
//    out word 0 first, lowest bank index first, one word per cycle while
//    the USB FIFO accepts data.
//
// Ports:
//    mclk  main clock, rising edge
//    rst   synchronous active-high reset
//    bus   usb_tx_buffer_if.slave (write side, USB FIFO side, status)
//
// Configuration:
//    USB_TX_PKTEND_EN  when defined, usb_pktend pulses for the one cycle
//                      spent in PKTEND; otherwise usb_pktend is tied low.

module usb_tx_buffer #(
   parameter int USB_DATA_NBIT     = 16,
   parameter int USB_ADDR_NBIT     = 8,
   parameter int BUFFER_BADDR_NBIT = 2
) (
   input  logic              mclk,
   input  logic              rst,
   usb_tx_buffer_if.slave    bus
);
   localparam int BUFFER_ADDR_NBIT = BUFFER_BADDR_NBIT + USB_ADDR_NBIT;
   localparam int NBANK            = 1 << BUFFER_BADDR_NBIT;
   localparam int NWORD_TOTAL      = 1 << BUFFER_ADDR_NBIT;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEL,
      ST_FETCH,
      ST_SEND,
      ST_PKTEND
   } state_t;

   state_t                        state;
   state_t                        state_nxt;

   logic [USB_DATA_NBIT-1:0]      mem [NWORD_TOTAL];

   logic [NBANK-1:0]              ready;
   logic [NBANK-1:0]              ready_nxt;
   logic [NBANK-1:0]              eop_vec;
   logic [NBANK-1:0]              pending;
   logic [BUFFER_BADDR_NBIT-1:0]  pick_bank;
   logic [BUFFER_BADDR_NBIT-1:0]  bank;
   logic [USB_ADDR_NBIT-1:0]      word;
   logic [USB_ADDR_NBIT-1:0]      word_inc;
   logic [USB_DATA_NBIT-1:0]      dout_r;
   logic                          ovf;
   logic                          resend;

   logic                          rd_en;
   logic [BUFFER_ADDR_NBIT-1:0]   rd_addr;
   logic                          xfer;
   logic                          last_word;
   logic                          sending;
   logic                          eop_on_bank;
   logic                          eop_ovf;

   // ---------------------------------------------------------------
   // Buffer RAM: write port from the decoder, registered read port
   // ---------------------------------------------------------------
   always_ff @(posedge mclk) begin
      if (!rst && bus.tx_vd) begin
         mem[bus.tx_addr] <= bus.tx_data;
      end
   end

   // ---------------------------------------------------------------
   // Ready bookkeeping
   // ---------------------------------------------------------------
   always_comb begin
      eop_vec = '0;
      for (int i = 0; i < NBANK; i++) begin
         eop_vec[i] = bus.tx_eop && (bus.tx_baddr == BUFFER_BADDR_NBIT'(i));
      end
   end

   // The bank completing this very cycle already counts, so a freshly
   // completed bank 0 still wins over a bank 2 that completed one cycle
   // earlier, and an idle bus starts moving without waiting for the
   // ready register.
   assign pending = ready | eop_vec;

   always_comb begin
      pick_bank = '0;
      for (int i = NBANK - 1; i >= 0; i--) begin
         if (pending[i]) begin
            pick_bank = BUFFER_BADDR_NBIT'(i);
         end
      end
   end

   assign sending     = (state == ST_FETCH) || (state == ST_SEND);
   assign xfer        = (state == ST_SEND) && !bus.usb_full;
   assign last_word   = &word;
   assign word_inc    = word + USB_ADDR_NBIT'(1);

   // A completion for the bank currently being read means its contents
   // may have changed under us: flag it and send the bank again.
   assign eop_on_bank = bus.tx_eop && sending && (bus.tx_baddr == bank);
   assign eop_ovf     = bus.tx_eop && (ready[bus.tx_baddr] || eop_on_bank);

   // Clear first, then OR in new completions so a tx_eop that lands on
   // the final word re-arms the bank instead of being lost.
   always_comb begin
      ready_nxt = ready;
      if (xfer && last_word && !resend) begin
         ready_nxt[bank] = 1'b0;
      end
      ready_nxt = ready_nxt | eop_vec;
   end

   // ---------------------------------------------------------------
   // FSM state register
   // ---------------------------------------------------------------
   always_ff @(posedge mclk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------------------------------------------------------
   // FSM next state and RAM read control
   // ---------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      rd_addr   = {bank, word_inc};
      case (state)
         ST_IDLE: begin
            if (|pending) begin
               state_nxt = ST_SEL;
            end
         end
         ST_SEL: begin
            state_nxt = ST_FETCH;
         end
         ST_FETCH: begin
            rd_en     = 1'b1;
            rd_addr   = {bank, {USB_ADDR_NBIT{1'b0}}};
            state_nxt = ST_SEND;
         end
         ST_SEND: begin
            // Read ahead only when the current word leaves; while the
            // FIFO is full dout_r simply holds.
            if (xfer) begin
               if (last_word) begin
                  state_nxt = ST_PKTEND;
               end else begin
                  rd_en = 1'b1;
               end
            end
         end
         ST_PKTEND: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------
   always_ff @(posedge mclk) begin
      if (rst) begin
         ready  <= '0;
         ovf    <= 1'b0;
         resend <= 1'b0;
         bank   <= '0;
         word   <= '0;
         dout_r <= '0;
      end else begin
         ready <= ready_nxt;
         if (eop_ovf) begin
            ovf <= 1'b1;
         end
         if (state == ST_SEL) begin
            bank   <= pick_bank;
            word   <= '0;
            resend <= 1'b0;
         end else if (eop_on_bank) begin
            resend <= 1'b1;
         end
         if (xfer && !last_word) begin
            word <= word_inc;
         end
         if (rd_en) begin
            dout_r <= mem[rd_addr];
         end
      end
   end

   // ---------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------
   assign bus.usb_wr   = xfer;
   assign bus.usb_dout = dout_r;
   assign bus.tx_busy  = (state != ST_IDLE) || (|ready);
   assign bus.tx_ovf   = ovf;

`ifdef USB_TX_PKTEND_EN
   assign bus.usb_pktend = (state == ST_PKTEND);
`else
   assign bus.usb_pktend = 1'b0;
`endif

endmodule

// File: tb/tb_usb_tx_buffer.sv
// tb/tb_usb_tx_buffer.sv - directed self-checking bench for usb_tx_buffer

module tb_usb_tx_buffer;
   localparam int DW = 16;
   localparam int AW = 8;
   localparam int BW = 2;

   logic mclk = 1'b0;
   logic rst  = 1'b1;
   always #5 mclk = ~mclk;

   usb_tx_buffer_if #(.USB_DATA_NBIT(DW), .USB_ADDR_NBIT(AW), .BUFFER_BADDR_NBIT(BW)) bus ();

   usb_tx_buffer #(.USB_DATA_NBIT(DW), .USB_ADDR_NBIT(AW), .BUFFER_BADDR_NBIT(BW)) dut (
      .mclk (mclk),
      .rst  (rst),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [DW-1:0] got[$];
   int wr_cyc[$];
   int pk_cyc[$];
   int wr_while_full = 0;

   always @(posedge mclk) cyc <= cyc + 1;

   always @(negedge mclk) begin
      if (bus.usb_wr) begin
         got.push_back(bus.usb_dout);
         wr_cyc.push_back(cyc);
      end
      if (bus.usb_pktend) pk_cyc.push_back(cyc);
      if (bus.usb_wr && bus.usb_full) wr_while_full++;
   end

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic clear_log();
      got.delete();
      wr_cyc.delete();
      pk_cyc.delete();
      wr_while_full = 0;
   endtask

   task automatic fill_bank(input int b);
      for (int w = 0; w < 256; w++) begin
         bus.tx_vd   = 1'b1;
         bus.tx_addr = 10'(b * 256 + w);
         bus.tx_data = 16'(b * 256 + w);
         tick();
      end
      bus.tx_vd = 1'b0;
   endtask

   task automatic pulse_eop(input int b, output int at);
      bus.tx_eop   = 1'b1;
      bus.tx_baddr = 2'(b);
      at = cyc;
      tick();
      bus.tx_eop = 1'b0;
   endtask

   task automatic wait_idle(input int budget, output bit timeout);
      int n = 0;
      while (bus.tx_busy && n < budget) begin
         tick();
         n++;
      end
      timeout = bus.tx_busy;
   endtask

   task automatic wait_words(input int count, input int budget, output bit timeout);
      int n = 0;
      while (got.size() < count && n < budget) begin
         tick();
         n++;
      end
      timeout = (got.size() < count);
   endtask

   task automatic test_reset();
      bus.tx_vd = 0; bus.tx_addr = 0; bus.tx_data = 0;
      bus.tx_eop = 0; bus.tx_baddr = 0; bus.usb_full = 0;
      rst = 1'b1;
      repeat (3) tick();
      checks++; if (bus.usb_wr !== 1'b0) begin errors++; $display("FAIL reset_usb_wr: got %b expected 0", bus.usb_wr); end
      checks++; if (bus.usb_dout !== 16'h0000) begin errors++; $display("FAIL reset_usb_dout: got %h expected 0000", bus.usb_dout); end
      checks++; if (bus.usb_pktend !== 1'b0) begin errors++; $display("FAIL reset_pktend: got %b expected 0", bus.usb_pktend); end
      checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.tx_busy); end
      checks++; if (bus.tx_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.tx_ovf); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_single();
      int e, bad, gaps, lat;
      bit to;
      fill_bank(1);
      clear_log();
      pulse_eop(1, e);
      wait_idle(2000, to);
      checks++; if (to) begin errors++; $display("FAIL single_timeout: busy still high"); end
      checks++; if (got.size() !== 256) begin errors++; $display("FAIL single_count: got %0d expected 256", got.size()); end
      bad = 0; gaps = 0;
      for (int i = 0; i < got.size(); i++) begin
         if (got[i] !== 16'(256 + i)) bad++;
         if (i > 0 && wr_cyc[i] != wr_cyc[i-1] + 1) gaps++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL single_data: %0d wrong words expected 0", bad); end
      checks++; if (gaps != 0) begin errors++; $display("FAIL single_gaps: %0d gaps expected 0", gaps); end
      lat = (wr_cyc.size() > 0) ? wr_cyc[0] - e : -1;
      checks++; if (lat < 1 || lat > 3) begin errors++; $display("FAIL single_latency: got %0d expected 1..3", lat); end
`ifdef USB_TX_PKTEND_EN
      checks++; if (pk_cyc.size() !== 1) begin errors++; $display("FAIL single_pktend_count: got %0d expected 1", pk_cyc.size()); end
      checks++;
      if (pk_cyc.size() == 0 || wr_cyc.size() == 0 || pk_cyc[0] != wr_cyc[wr_cyc.size()-1] + 1) begin
         errors++; $display("FAIL single_pktend_pos: pktend not the cycle after last word");
      end
`else
      checks++; if (pk_cyc.size() !== 0) begin errors++; $display("FAIL single_pktend_off: got %0d pulses expected 0", pk_cyc.size()); end
`endif
   endtask

   task automatic test_backpressure();
      int bad;
      bit to;
      clear_log();
      to = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         bus.usb_full = ((n / 3) % 2) == 1;
         bus.tx_eop   = (n == 0);
         bus.tx_baddr = 2'd1;
         tick();
         if (n > 2 && !bus.tx_busy) begin
            to = 1'b0;
            break;
         end
      end
      bus.tx_eop = 1'b0;
      bus.usb_full = 1'b0;
      checks++; if (to) begin errors++; $display("FAIL bp_timeout: busy still high"); end
      checks++; if (got.size() !== 256) begin errors++; $display("FAIL bp_count: got %0d expected 256", got.size()); end
      bad = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== 16'(256 + i)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL bp_order: %0d wrong words expected 0", bad); end
      checks++; if (wr_while_full != 0) begin errors++; $display("FAIL bp_wr_when_full: got %0d expected 0", wr_while_full); end
   endtask

   task automatic test_priority();
      int e, bad;
      bit to;
      fill_bank(0);
      fill_bank(2);
      clear_log();
      pulse_eop(2, e);
      pulse_eop(0, e);
      wait_idle(3000, to);
      checks++; if (to) begin errors++; $display("FAIL prio_timeout: busy still high"); end
      checks++; if (got.size() !== 512) begin errors++; $display("FAIL prio_count: got %0d expected 512", got.size()); end
      bad = 0;
      for (int i = 0; i < got.size(); i++) begin
         if (i < 256) begin
            if (got[i] !== 16'(i)) bad++;
         end else begin
            if (got[i] !== 16'(512 + i - 256)) bad++;
         end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL prio_order: %0d wrong words expected 0", bad); end
      checks++; if (bus.tx_ovf !== 1'b0) begin errors++; $display("FAIL prio_no_ovf: got %b expected 0", bus.tx_ovf); end
`ifdef USB_TX_PKTEND_EN
      checks++; if (pk_cyc.size() !== 2) begin errors++; $display("FAIL prio_pktend: got %0d expected 2", pk_cyc.size()); end
`endif
   endtask

   task automatic test_overflow();
      int e, bad;
      bit to;
      // second completion of bank 1 in mid-packet
      clear_log();
      pulse_eop(1, e);
      wait_words(50, 500, to);
      checks++; if (to) begin errors++; $display("FAIL ovf_wait50: only %0d words", got.size()); end
      checks++; if (bus.tx_ovf !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0", bus.tx_ovf); end
      pulse_eop(1, e);
      checks++; if (bus.tx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.tx_ovf); end
      wait_idle(3000, to);
      checks++; if (to) begin errors++; $display("FAIL ovf_timeout: busy still high"); end
      checks++; if (got.size() !== 512) begin errors++; $display("FAIL ovf_resend_count: got %0d expected 512", got.size()); end
      bad = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== 16'(256 + (i % 256))) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL ovf_resend_data: %0d wrong words expected 0", bad); end
      // completion landing exactly on the final word
      clear_log();
      pulse_eop(1, e);
      wait_words(255, 600, to);
      checks++; if (to) begin errors++; $display("FAIL last_wait255: only %0d words", got.size()); end
      checks++; if (bus.usb_wr !== 1'b1) begin errors++; $display("FAIL last_wr: got %b expected 1", bus.usb_wr); end
      pulse_eop(1, e);
      wait_idle(3000, to);
      checks++; if (got.size() !== 512) begin errors++; $display("FAIL last_resend_count: got %0d expected 512", got.size()); end
      bad = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== 16'(256 + (i % 256))) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL last_resend_data: %0d wrong words expected 0", bad); end
      checks++; if (bus.tx_ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.tx_ovf); end
   endtask

   task automatic test_reset_mid();
      int e, bad;
      bit to;
      clear_log();
      pulse_eop(1, e);
      wait_words(100, 600, to);
      checks++; if (to) begin errors++; $display("FAIL mid_wait100: only %0d words", got.size()); end
      // reset while word 100 is on the bus; write and eop must be ignored
      rst = 1'b1;
      bus.tx_vd = 1'b1; bus.tx_addr = 10'h100; bus.tx_data = 16'hDEAD;
      bus.tx_eop = 1'b1; bus.tx_baddr = 2'd3;
      tick();
      rst = 1'b0;
      bus.tx_vd = 1'b0;
      bus.tx_eop = 1'b0;
      checks++; if (bus.usb_wr !== 1'b0) begin errors++; $display("FAIL mid_usb_wr: got %b expected 0", bus.usb_wr); end
      checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", bus.tx_busy); end
      checks++; if (bus.tx_ovf !== 1'b0) begin errors++; $display("FAIL mid_ovf: got %b expected 0", bus.tx_ovf); end
      checks++; if (bus.usb_dout !== 16'h0000) begin errors++; $display("FAIL mid_dout: got %h expected 0000", bus.usb_dout); end
      repeat (10) tick();
      checks++; if (got.size() !== 101) begin errors++; $display("FAIL mid_no_more_wr: got %0d words expected 101", got.size()); end
      checks++; if (bus.tx_busy !== 1'b0) begin errors++; $display("FAIL mid_eop_ignored: busy %b expected 0", bus.tx_busy); end
      clear_log();
      pulse_eop(1, e);
      wait_idle(2000, to);
      checks++; if (got.size() !== 256) begin errors++; $display("FAIL mid_restart_count: got %0d expected 256", got.size()); end
      bad = 0;
      for (int i = 0; i < got.size(); i++) if (got[i] !== 16'(256 + i)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL mid_restart_data: %0d wrong words expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_priority();
      test_overflow();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/usb_tx_buffer.md
USB_TX_BUFFER -- requirements
Module: usb_tx_buffer

Interface
REQ-001 mclk  input  1  main clock, 48 MHz; all logic on rising edge.
REQ-002 rst  input  1  reset; synchronous, active-high.
REQ-003 tx_vd  input  1  write strobe from the command decoder.
REQ-004 tx_addr  input  BUFFER_ADDR_NBIT  write address {bank, word}; bank = upper BUFFER_BADDR_NBIT bits, word = lower USB_ADDR_NBIT bits.
REQ-005 tx_data  input  USB_DATA_NBIT  write data.
REQ-006 tx_eop  input  1  one-cycle pulse; the bank named by tx_baddr is complete.
REQ-007 tx_baddr  input  BUFFER_BADDR_NBIT  completed bank index; qualified by tx_eop.
REQ-008 usb_full  input  1  USB FIFO full, active-high.
REQ-009 usb_wr  output  1  USB FIFO write; a word transfers on each cycle with usb_wr=1.
REQ-010 usb_dout  output  USB_DATA_NBIT  USB FIFO data; valid whenever usb_wr=1.
REQ-011 usb_pktend  output  1  packet-end pulse (see Configuration).
REQ-012 tx_busy  output  1  high while any bank is pending or being sent.
REQ-013 tx_ovf  output  1  sticky overflow flag.

Function
REQ-014 Storage SHALL be 2^BUFFER_BADDR_NBIT banks x 2^USB_ADDR_NBIT words of USB_DATA_NBIT, one write port and one read port.
REQ-015 tx_vd=1 SHALL write tx_data at tx_addr that cycle, regardless of read activity.
REQ-016 tx_eop=1 SHALL set ready[tx_baddr].
REQ-017 States: IDLE, SEL, FETCH, SEND, PKTEND; default -> IDLE.
REQ-018 IDLE: any ready bit set -> SEL; else stay.
REQ-019 SEL: choose lowest-index ready bank (bank 0 handshake first); latch it; word counter = 0 -> FETCH.
REQ-020 FETCH: issue RAM read of word 0 (1-cycle RAM latency) -> SEND.
REQ-021 SEND: usb_wr = !usb_full, combinationally gated; usb_dout is registered RAM data.
REQ-022 SEND SHALL sustain one word per cycle while usb_full=0, using a read-ahead address.
REQ-023 While usb_full=1, usb_dout SHALL hold and no word SHALL be lost or repeated.
REQ-024 Words SHALL go out in order 0 .. 2^USB_ADDR_NBIT-1.
REQ-025 On transfer of the last word: clear ready[bank] -> PKTEND.
REQ-026 PKTEND -> IDLE after one cycle.
REQ-027 First usb_wr SHALL come no later than 3 cycles after tx_eop, with bus idle and usb_full=0.
REQ-028 tx_eop for a bank whose ready bit is already set, or for the bank being sent, SHALL set tx_ovf. The ready bit SHALL then be set.
REQ-029 tx_eop in the same cycle that the same bank's ready bit clears: the set wins, and the bank is resent.
REQ-030 tx_busy = (state != IDLE) | (|ready).

Reset
REQ-031 rst=1 SHALL force: state IDLE, ready=0, tx_ovf=0, usb_wr=0, usb_pktend=0, usb_dout=0, tx_busy=0; effective the cycle after rst is sampled.
REQ-032 Reset mid-SEND SHALL abort the packet with no further usb_wr. RAM contents are not cleared.
REQ-033 tx_vd and tx_eop SHALL be ignored while rst=1.

Configuration
REQ-034 Macro USB_TX_PKTEND_EN: when defined, usb_pktend SHALL pulse for exactly 1 cycle in state PKTEND.
REQ-035 When USB_TX_PKTEND_EN is undefined, usb_pktend SHALL be tied 0 and PKTEND still lasts 1 cycle.

Verification (USB_DATA_NBIT=16, USB_ADDR_NBIT=8, BUFFER_BADDR_NBIT=2)
REQ-036 Fill bank 1 with data=addr, then tx_eop, baddr=1, usb_full=0 -> 256 consecutive usb_wr cycles, dout 0x0100..0x01FF, first within 3 cycles, then pktend pulse (with macro).
REQ-037 Same packet with usb_full toggling 1/0 every 3 cycles -> exactly 256 transfers, no duplicates or gaps, order preserved.
REQ-038 tx_eop for banks 2 and 0 in the same idle window -> bank 0 sent fully before bank 2.
REQ-039 tx_eop baddr=1 twice before the send completes -> tx_ovf=1 and sticky until rst; bank 1 sent twice.
REQ-040 rst pulse at word 100 of a send -> usb_wr=0 from the next cycle, tx_busy=0, tx_ovf=0; a new tx_eop restarts from word 0.
REQ-041 Build without USB_TX_PKTEND_EN -> usb_pktend stays 0 throughout REQ-036, and all other outputs are identical.
